// File: rtl/core_sync_if.sv
// Host/core handshake bundle for core_sync_ctrl: launch request, per-core
// ready/done/start and run status back to the host.
interface core_sync_if #(
    parameter int CORE_COUNT    = 4,
    parameter int CYCLE_WIDTH   = 32,
    parameter int TIMEOUT_WIDTH = 20
);
    logic                     host_go;
    logic [CORE_COUNT-1:0]    core_mask;
    logic [TIMEOUT_WIDTH-1:0] timeout_limit;
    logic [CORE_COUNT-1:0]    core_ready;
    logic [CORE_COUNT-1:0]    core_done;
    logic [CORE_COUNT-1:0]    core_start;
    logic                     busy;
    logic                     all_done;
    logic                     timeout_err;
    logic [CORE_COUNT-1:0]    done_mask;
    logic [CYCLE_WIDTH-1:0]   run_cycles;

    modport master (
        output host_go, core_mask, timeout_limit, core_ready, core_done,
        input  core_start, busy, all_done, timeout_err, done_mask, run_cycles
    );

    modport slave (
        input  host_go, core_mask, timeout_limit, core_ready, core_done,
        output core_start, busy, all_done, timeout_err, done_mask, run_cycles
    );
endinterface

// File: rtl/core_sync_ctrl.sv
// Launch/completion coordinator for a masked set of cores.
// Optional run watchdog enabled by defining CORE_SYNC_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for host_go
// WAIT_RDY | waiting for every masked core to report ready
// LAUNCH   | single-cycle start pulse to masked cores
// RUN      | collecting done, counting cycles
// FINISH   | single-cycle all_done pulse
// ABORT    | watchdog expired, flag error (watchdog build only)
module core_sync_ctrl #(
    parameter int CORE_COUNT    = 4,
    parameter int CYCLE_WIDTH   = 32,
    parameter int TIMEOUT_WIDTH = 20
) (
    input  logic      clk,
    input  logic      rst,
    core_sync_if.slave bus
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_RDY = 3'd1;
    localparam logic [2:0] ST_LAUNCH   = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;
    localparam logic [2:0] ST_ABORT    = 3'd5;

    logic [2:0]             state;
    logic [CORE_COUNT-1:0]  mask_q;
    logic [CORE_COUNT-1:0]  done_mask_q;
    logic [CORE_COUNT-1:0]  done_next;
    logic [CYCLE_WIDTH-1:0] run_cycles_q;
    logic [CYCLE_WIDTH-1:0] run_next;
    logic                   accept_go;
    logic                   run_complete;
    logic                   wd_abort;

    always_comb begin
        done_next    = done_mask_q | (bus.core_done & mask_q);
        run_next     = (&run_cycles_q) ? run_cycles_q : run_cycles_q + CYCLE_WIDTH'(1);
        accept_go    = (state == ST_IDLE) && bus.host_go;
        run_complete = (done_next == mask_q);
    end

`ifdef CORE_SYNC_TIMEOUT_EN
    localparam int CMP_W = (CYCLE_WIDTH > TIMEOUT_WIDTH) ? CYCLE_WIDTH : TIMEOUT_WIDTH;

    logic [TIMEOUT_WIDTH-1:0] limit_q;
    logic                     timeout_err_q;

    // Completion on the limit cycle takes priority over the abort.
    assign wd_abort = (state == ST_RUN) && !run_complete && (limit_q != '0)
                      && (CMP_W'(run_next) == CMP_W'(limit_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit_q       <= '0;
            timeout_err_q <= 1'b0;
        end else if (accept_go) begin
            limit_q       <= bus.timeout_limit;
            timeout_err_q <= 1'b0;
        end else if (wd_abort) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    logic unused_limit;

    assign unused_limit    = ^bus.timeout_limit;
    assign wd_abort        = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            mask_q       <= '0;
            done_mask_q  <= '0;
            run_cycles_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_go) begin
                        mask_q       <= bus.core_mask;
                        done_mask_q  <= '0;
                        run_cycles_q <= '0;
                        state        <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    // An empty mask has nothing to launch or wait for.
                    if (mask_q == '0)
                        state <= ST_FINISH;
                    else if ((bus.core_ready & mask_q) == mask_q)
                        state <= ST_LAUNCH;
                end
                ST_LAUNCH: state <= ST_RUN;
                ST_RUN: begin
                    done_mask_q  <= done_next;
                    run_cycles_q <= run_next;
                    if (run_complete)
                        state <= ST_FINISH;
                    else if (wd_abort)
                        state <= ST_ABORT;
                end
                ST_FINISH: state <= ST_IDLE;
                ST_ABORT:  state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign bus.core_start = (state == ST_LAUNCH) ? mask_q : '0;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.all_done   = (state == ST_FINISH);
    assign bus.done_mask  = done_mask_q;
    assign bus.run_cycles = run_cycles_q;
endmodule
